// File: rtl/clarke_inverse_pipe.sv
`default_nettype none
// clarke_inverse_pipe: three-stage AXI-Stream inverse Clarke transform (alpha/beta -> a/b/c)
// with per-phase saturation flags and optional min/max zero-sequence injection.
module clarke_inverse_pipe #(
    parameter int DW     = 16,
    parameter int FRAC   = 15,
    parameter int K      = 28378,
    parameter int INJECT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4*DW-1:0] s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic [4*DW-1:0] m_axis_tdata,
    output logic [2:0]      m_axis_tuser,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready
);

    localparam int PW = DW + FRAC + 1;
    localparam int SW = DW + 3;
    localparam logic signed [FRAC:0]   KS   = (FRAC+1)'(K);
    localparam logic signed [PW-1:0]   HALF = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [SW-1:0]   MAXV = SW'((2**(DW-1)) - 1);
    localparam logic signed [SW-1:0]   MINV = -MAXV;

    logic ce;
    assign ce            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ce;

    // Top lane of the input word carries nothing for this block.
    logic unused_top;
    assign unused_top = ^s_axis_tdata[4*DW-1:3*DW];

    // Stage 1: operand capture and beta*K product
    logic signed [DW-1:0] alpha_in, beta_in;
    logic signed [PW-1:0] p_next;
    assign alpha_in = s_axis_tdata[DW-1:0];
    assign beta_in  = s_axis_tdata[2*DW-1:DW];
    assign p_next   = PW'(beta_in) * PW'(KS);

    logic                 v1;
    logic signed [DW-1:0] alpha1;
    logic [DW-1:0]        theta1;
    logic signed [PW-1:0] p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            alpha1 <= '0;
            theta1 <= '0;
            p1     <= '0;
        end else if (ce) begin
            v1     <= s_axis_tvalid;
            alpha1 <= alpha_in;
            theta1 <= s_axis_tdata[3*DW-1:2*DW];
            p1     <= p_next;
        end
    end

    // Stage 2: rounded sqrt(3)/2*beta and floored alpha/2, full width
    logic signed [PW-1:0] rnd;
    logic signed [SW-1:0] t_w, h_w, va_w, vb_w, vc_w;
    assign rnd  = p1 + HALF;
    assign t_w  = SW'(rnd >>> FRAC);
    assign h_w  = SW'(alpha1) >>> 1;
    assign va_w = SW'(alpha1);
    assign vb_w = t_w - h_w;
    assign vc_w = -t_w - h_w;

    logic                 v2;
    logic [DW-1:0]        theta2;
    logic signed [SW-1:0] va2, vb2, vc2;

    always_ff @(posedge clk) begin
        if (reset) begin
            v2     <= 1'b0;
            theta2 <= '0;
            va2    <= '0;
            vb2    <= '0;
            vc2    <= '0;
        end else if (ce) begin
            v2     <= v1;
            theta2 <= theta1;
            va2    <= va_w;
            vb2    <= vb_w;
            vc2    <= vc_w;
        end
    end

    // Stage 3: optional zero-sequence injection, then symmetric saturation
    function automatic logic signed [SW-1:0] max3(input logic signed [SW-1:0] x, y, z);
        logic signed [SW-1:0] m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

    function automatic logic signed [SW-1:0] min3(input logic signed [SW-1:0] x, y, z);
        logic signed [SW-1:0] m;
        m = (x < y) ? x : y;
        return (m < z) ? m : z;
    endfunction

    function automatic logic [DW:0] sat(input logic signed [SW-1:0] x);
        if (x > MAXV)
            return {1'b1, MAXV[DW-1:0]};
        else if (x < MINV)
            return {1'b1, MINV[DW-1:0]};
        else
            return {1'b0, x[DW-1:0]};
    endfunction

    logic signed [SW-1:0] z_w;

    generate
        if (INJECT != 0) begin : g_inject
            logic signed [SW-1:0] mx, mn;
            assign mx  = max3(va2, vb2, vc2);
            assign mn  = min3(va2, vb2, vc2);
            assign z_w = -((mx + mn) >>> 1);
        end else begin : g_plain
            assign z_w = '0;
        end
    endgenerate

    logic [DW:0] sa, sb, sc;
    assign sa = sat(va2 + z_w);
    assign sb = sat(vb2 + z_w);
    assign sc = sat(vc2 + z_w);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
        end else if (ce) begin
            m_axis_tvalid <= v2;
            m_axis_tdata  <= {theta2, sc[DW-1:0], sb[DW-1:0], sa[DW-1:0]};
            m_axis_tuser  <= {sc[DW], sb[DW], sa[DW]};
        end
    end

endmodule
`default_nettype wire
